// File: rtl/audio_lpr_fir_decim_pkg.sv
// Shared constants, coefficient table and dequantize helper for the audio LPR chain.
package audio_lpr_fir_decim_pkg;

  localparam int AUDIO_DATA_W   = 32;
  localparam int AUDIO_NUM_TAPS = 32;
  localparam int AUDIO_DECIM    = 8;
  localparam int QUANT_BITS     = 10;

  // Symmetric low-pass taps in Q10.
  localparam logic signed [AUDIO_DATA_W-1:0] AUDIO_LPR_COEFFS [AUDIO_NUM_TAPS] = '{
    -32'sd1,  -32'sd2,  -32'sd4,  -32'sd5,  -32'sd3,  32'sd3,  32'sd12, 32'sd24,
     32'sd38,  32'sd52,  32'sd65,  32'sd75,  32'sd83, 32'sd88, 32'sd92, 32'sd94,
     32'sd94,  32'sd92,  32'sd88,  32'sd83,  32'sd75, 32'sd65, 32'sd52, 32'sd38,
     32'sd24,  32'sd12,  32'sd3,  -32'sd3,  -32'sd5, -32'sd4, -32'sd2, -32'sd1
  };

  localparam logic signed [2*AUDIO_DATA_W-1:0] DEQ_BIAS =
    (2*AUDIO_DATA_W)'((1 << QUANT_BITS) - 1);

  // Division by 2**QUANT_BITS truncating toward zero: negative products are
  // biased up before the arithmetic shift so that e.g. -3 maps to 0, not -1.
  function automatic logic signed [AUDIO_DATA_W-1:0] DEQUANTIZE_I(
    input logic signed [2*AUDIO_DATA_W-1:0] p
  );
    logic signed [2*AUDIO_DATA_W-1:0] biased;
    biased = p[2*AUDIO_DATA_W-1] ? p + DEQ_BIAS : p;
    return AUDIO_DATA_W'(biased >>> QUANT_BITS);
  endfunction

endpackage

// File: rtl/audio_lpr_fir_decim_if.sv
// Input-FIFO pop side and output-FIFO push side of the decimating FIR.
interface audio_lpr_fir_decim_if
  import audio_lpr_fir_decim_pkg::*;
#(
  parameter int DATA_W = AUDIO_DATA_W
);
  logic                     x_in_rd_en;
  logic                     x_in_empty;
  logic signed [DATA_W-1:0] x_in;
  logic signed [DATA_W-1:0] y_out;
  logic                     y_out_wr_en;
  logic                     y_out_full;

  modport master (
    output x_in_empty, x_in, y_out_full,
    input  x_in_rd_en, y_out, y_out_wr_en
  );

  modport slave (
    input  x_in_empty, x_in, y_out_full,
    output x_in_rd_en, y_out, y_out_wr_en
  );
endinterface

// File: rtl/audio_lpr_fir_decim_fir_mac_unit.sv
// Combinational FIR tap step: acc + DEQ(coeff * sample), wrapping, no saturation.
module fir_mac_unit
  import audio_lpr_fir_decim_pkg::*;
#(
  parameter int DATA_W = AUDIO_DATA_W
) (
  input  logic signed [DATA_W-1:0] acc,
  input  logic signed [DATA_W-1:0] coeff,
  input  logic signed [DATA_W-1:0] sample,
  output logic signed [DATA_W-1:0] sum
);
  logic signed [2*DATA_W-1:0] prod;

  always_comb begin
    prod = (2*DATA_W)'(coeff) * (2*DATA_W)'(sample);
    sum  = acc + DEQUANTIZE_I(prod);
  end
endmodule

// File: rtl/audio_lpr_fir_decim.sv
// Decimating audio low-pass FIR: collects DECIM samples, then runs one MAC per clock.
module audio_lpr_fir_decim
  import audio_lpr_fir_decim_pkg::*;
#(
  parameter int DATA_W   = AUDIO_DATA_W,
  parameter int NUM_TAPS = AUDIO_NUM_TAPS,
  parameter int DECIM    = AUDIO_DECIM
) (
  input  logic                 clk,
  input  logic                 rst,
  audio_lpr_fir_decim_if.slave bus
);
  localparam int TAP_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int CNT_W = $clog2(DECIM + 1);

  typedef enum logic [1:0] {FILL, MAC, WRITE} state_t;

  state_t                   state, state_nxt;
  logic                     armed;
  logic signed [DATA_W-1:0] hist [NUM_TAPS];
  logic signed [DATA_W-1:0] acc, acc_nxt;
  logic [TAP_W-1:0]         tap;
  logic [CNT_W-1:0]         cnt;
  logic                     pop, push, last_smp, last_tap;

  assign last_smp = (cnt == CNT_W'(DECIM - 1));
  assign last_tap = (tap == TAP_W'(NUM_TAPS - 1));

  fir_mac_unit #(.DATA_W(DATA_W)) u_mac (
    .acc    (acc),
    .coeff  (AUDIO_LPR_COEFFS[tap]),
    .sample (hist[tap]),
    .sum    (acc_nxt)
  );

  // armed keeps both strobes low for the first clock after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    push      = 1'b0;
    unique case (state)
      FILL: begin
        pop = armed && !bus.x_in_empty;
        if (pop && last_smp) state_nxt = MAC;
      end
      MAC: begin
        if (last_tap) state_nxt = WRITE;
      end
      WRITE: begin
        push = armed && !bus.y_out_full;
        if (push) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  assign bus.x_in_rd_en  = pop;
  assign bus.y_out_wr_en = push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_TAPS; i++) hist[i] <= '0;
      acc       <= '0;
      tap       <= '0;
      cnt       <= '0;
      bus.y_out <= '0;
    end else begin
      if (pop) begin
        hist[0] <= bus.x_in;
        for (int i = 1; i < NUM_TAPS; i++) hist[i] <= hist[i-1];
        cnt <= last_smp ? '0 : cnt + 1'b1;
        if (last_smp) begin
          acc <= '0;
          tap <= '0;
        end
      end
      if (state == MAC) begin
        acc <= acc_nxt;
        tap <= tap + 1'b1;
        if (last_tap) bus.y_out <= acc_nxt;
      end
    end
  end
endmodule

// File: tb/tb_audio_lpr_fir_decim.sv
// Directed bench for the decimating FIR with FIFO models on both sides.
module tb_audio_lpr_fir_decim;
  import audio_lpr_fir_decim_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  audio_lpr_fir_decim_if #(.DATA_W(AUDIO_DATA_W)) bus ();

  audio_lpr_fir_decim dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  int src_q [$];
  int ref_q [$];
  int out_q [$];
  int wr_cyc [$];
  int pops = 0;
  int cyc  = 0;
  bit pend_pop  = 1'b0;
  bit gap       = 1'b0;
  bit full_hold = 1'b0;

  // FIFO models: inputs change at negedge, strobes sampled 1 time unit later
  initial begin
    bus.x_in       = 0;
    bus.x_in_empty = 1'b1;
    bus.y_out_full = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (pend_pop && src_q.size() != 0) begin
        void'(src_q.pop_front());
        pops++;
      end
      bus.x_in_empty = gap || (src_q.size() == 0);
      bus.x_in       = (src_q.size() != 0) ? src_q[0] : 0;
      bus.y_out_full = full_hold;
      #1;
      pend_pop = bus.x_in_rd_en;
      if (bus.y_out_wr_en) begin
        out_q.push_back(bus.y_out);
        wr_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic feed(input int v);
    src_q.push_back(v);
    ref_q.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    pend_pop = 1'b0;
    src_q.delete(); ref_q.delete(); out_q.delete(); wr_cyc.delete();
    pops = 0; gap = 1'b0; full_hold = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic wait_out(input int n, input int budget, input string tag);
    int k = 0;
    while (out_q.size() < n && k < budget) begin
      step(1);
      k++;
    end
    if (out_q.size() < n) chk({tag, "_timeout"}, out_q.size(), n);
  endtask

  task automatic wait_pops(input int n, input int budget, input string tag);
    int k = 0;
    while (pops < n && k < budget) begin
      step(1);
      k++;
    end
    if (pops < n) chk({tag, "_pop_timeout"}, pops, n);
  endtask

  function automatic logic signed [31:0] out_at(input int i);
    return (out_q.size() > i) ? out_q[i] : 'x;
  endfunction

  function automatic int period_at(input int i);
    return (wr_cyc.size() > i) ? wr_cyc[i] - wr_cyc[i-1] : -1;
  endfunction

  // Straight C-style reference: 64-bit product, division truncating toward zero
  function automatic logic signed [31:0] model(input int m);
    int     acc = 0;
    longint p;
    int     n   = (m + 1) * AUDIO_DECIM - 1;
    for (int i = 0; i < AUDIO_NUM_TAPS; i++) begin
      if (n - i >= 0 && n - i < ref_q.size()) begin
        p   = longint'(AUDIO_LPR_COEFFS[i]) * longint'(ref_q[n-i]);
        acc += int'(p / (longint'(1) << QUANT_BITS));
      end
    end
    return acc;
  endfunction

  task automatic run_impulse(input string tag);
    do_reset();
    feed(1024);
    repeat (39) feed(0);
    wait_out(5, 400, tag);
    chk({tag, "_y0"}, out_at(0), 24);
    chk({tag, "_y1"}, out_at(1), 94);
    chk({tag, "_y2"}, out_at(2), 38);
    chk({tag, "_y3"}, out_at(3), -1);
    chk({tag, "_y4"}, out_at(4), 0);
    chk({tag, "_period12"}, period_at(2), 41);
    chk({tag, "_period34"}, period_at(4), 41);
    step(60);
    chk({tag, "_pops"}, pops, 40);
    chk({tag, "_nout"}, out_q.size(), 5);
  endtask

  initial begin
    logic signed [31:0] y_hold;

    // reset state with a non-empty input FIFO
    src_q.push_back(5);
    step(2);
    chk("rst_rd_en", 32'(bus.x_in_rd_en), 0);
    chk("rst_wr_en", 32'(bus.y_out_wr_en), 0);
    chk("rst_y_out", bus.y_out, 0);

    run_impulse("imp");

    // DC at unity: partial sums then full sum(h)
    do_reset();
    repeat (48) feed(1024);
    wait_out(6, 500, "dc");
    for (int k = 0; k < 6; k++) chk($sformatf("dc_y%0d", k), out_at(k), model(k));
    chk("dc_y0_hand", out_at(0), 24);
    chk("dc_y4_hand", out_at(4), 1222);
    chk("dc_y5_hand", out_at(5), 1222);

    // DC at full scale: accumulator wraps
    do_reset();
    repeat (48) feed(32'h7FFF_FFFF);
    wait_out(6, 500, "dcmax");
    for (int k = 0; k < 6; k++) chk($sformatf("dcmax_y%0d", k), out_at(k), model(k));
    chk("dcmax_y5_hand", out_at(5), -32'sd1732247564);

    // truncation toward zero on negative products
    do_reset();
    repeat (7) feed(0); feed(3);
    repeat (7) feed(0); feed(1500);
    repeat (7) feed(0); feed(-2048);
    wait_out(3, 300, "trunc");
    chk("trunc_deq_m3", out_at(0), 0);
    chk("trunc_deq_m1500", out_at(1), -1);
    chk("trunc_deq_p2048", out_at(2), 57);

    // backpressure at WRITE
    do_reset();
    full_hold = 1'b1;
    repeat (8) feed(1024);
    repeat (8) feed(7);
    wait_pops(8, 40, "bp");
    step(33);
    y_hold = bus.y_out;
    chk("bp_y_hold", y_hold, 24);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_rd_en%0d", k), 32'(bus.x_in_rd_en), 0);
      chk($sformatf("bp_wr_en%0d", k), 32'(bus.y_out_wr_en), 0);
      chk($sformatf("bp_y_stable%0d", k), bus.y_out, y_hold);
      step(1);
    end
    chk("bp_pops_held", pops, 8);
    full_hold = 1'b0;
    step(3);
    chk("bp_one_write", out_q.size(), 1);
    chk("bp_y_written", out_at(0), 24);
    step(12);
    chk("bp_fill_resumed", pops, 16);

    // input starvation mid-block
    do_reset();
    feed(100); feed(-200); feed(300);
    wait_pops(3, 20, "starve");
    gap = 1'b1;
    feed(400); feed(-500); feed(600); feed(700); feed(-800);
    step(10);
    chk("starve_pops", pops, 3);
    chk("starve_rd_en", 32'(bus.x_in_rd_en), 0);
    chk("starve_nout", out_q.size(), 0);
    gap = 1'b0;
    wait_out(1, 100, "starve");
    chk("starve_y0_model", out_at(0), model(0));
    chk("starve_y0_hand", out_at(0), -2);

    // reset in the middle of the second MAC pass
    do_reset();
    feed(1024);
    repeat (15) feed(0);
    wait_out(1, 100, "midrst");
    chk("midrst_y_pre", bus.y_out, 24);
    wait_pops(16, 40, "midrst");
    step(12);
    rst = 1'b1;
    pend_pop = 1'b0;
    #1;
    chk("midrst_y_out", bus.y_out, 0);
    chk("midrst_rd_en", 32'(bus.x_in_rd_en), 0);
    chk("midrst_wr_en", 32'(bus.y_out_wr_en), 0);
    run_impulse("imp_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
